// File: rtl/isi_channel_pkg.sv
// rtl/isi_channel_pkg.sv - shared types and arithmetic helpers for the ISI FIR channel
package isi_channel_pkg;

   localparam int DEF_COEF_WIDTH = 8;

   typedef logic signed [DEF_COEF_WIDTH-1:0] coef_t;

   // Full-precision accumulator width: product width plus growth for L additions
   function automatic int acc_width(input int sr, input int cw, input int l);
      return sr + cw + $clog2(l);
   endfunction

   // Clip a wide signed value into the signed range of an sr-bit word
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int sr);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (sr - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (sr - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

   // Legacy channel h = [1.0, 0.5, 0, ...] in the tap fixed-point format
   function automatic int default_tap(input int k, input int frac);
      if (k == 0) begin
         return 1 << frac;
      end else if (k == 1) begin
         return 1 << (frac - 1);
      end
      return 0;
   endfunction

endpackage

// File: rtl/isi_tap_bank.sv
// rtl/isi_tap_bank.sv - shadow/active tap register pair with atomic commit
module isi_tap_bank
   import isi_channel_pkg::*;
#(
   parameter int L    = 4,
   parameter int CW   = 8,
   parameter int FRAC = 6,
   parameter int AW   = $clog2(L)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en_i,
   input  logic [AW-1:0]   wr_addr_i,
   input  logic [CW-1:0]   wr_data_i,
   input  logic            commit_i,
   output logic [L*CW-1:0] active_o
);

   logic [CW-1:0] shadow_q [L];
   logic [CW-1:0] shadow_d [L];
   logic [CW-1:0] active_q [L];

   // Next shadow contents; a commit sees a write made in the same cycle
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en_i && (32'(wr_addr_i) < 32'(L))) begin
         shadow_d[wr_addr_i] = wr_data_i;
      end
   end

   // Shadow always follows writes; active only moves on commit
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < L; k++) begin
            shadow_q[k] <= CW'(default_tap(k, FRAC));
            active_q[k] <= CW'(default_tap(k, FRAC));
         end
      end else begin
         shadow_q <= shadow_d;
         if (commit_i) begin
            active_q <= shadow_d;
         end
      end
   end

   // Flatten the active bank, tap 0 in the low bits
   always_comb begin
      active_o = '0;
      for (int k = 0; k < L; k++) begin
         active_o[k*CW +: CW] = active_q[k];
      end
   end

endmodule

// File: rtl/isi_fir_channel.sv
// rtl/isi_fir_channel.sv - ISI channel: 2-stage FIR with rounding, saturation and clip counter
module isi_fir_channel
   import isi_channel_pkg::*;
#(
   parameter int PULSE_RESPONSE_LENGTH = 4,
   parameter int SIGNAL_RESOLUTION     = 8,
   parameter int COEF_WIDTH            = 8,
   parameter int COEF_FRAC             = 6
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic signed [SIGNAL_RESOLUTION-1:0]      signal_in,
   input  logic                                     signal_in_valid,
   input  logic                                     coef_wr_en,
   input  logic [$clog2(PULSE_RESPONSE_LENGTH)-1:0] coef_wr_addr,
   input  logic [COEF_WIDTH-1:0]                    coef_wr_data,
   input  logic                                     coef_commit,
   output logic signed [SIGNAL_RESOLUTION-1:0]      signal_out,
   output logic                                     signal_out_valid,
   output logic                                     sat_flag,
   output logic [15:0]                              sat_count
);

   localparam int L      = PULSE_RESPONSE_LENGTH;
   localparam int SR     = SIGNAL_RESOLUTION;
   localparam int CW     = COEF_WIDTH;
   localparam int PW     = SR + CW;
   localparam int ACC    = acc_width(SR, CW, L);
   localparam int RW     = ACC - COEF_FRAC;
   localparam int HALF_I = 1 << (COEF_FRAC - 1);

   logic [L*CW-1:0]         taps_flat;
   logic signed [CW-1:0]    h        [L];
   logic signed [SR-1:0]    x_q      [L];
   logic signed [SR-1:0]    x_d      [L];
   logic signed [PW-1:0]    prod_d   [L];
   logic signed [PW-1:0]    prod_q   [L];
   logic                    v1_q;
   logic signed [ACC-1:0]   sum_d;
   logic signed [ACC-1:0]   rnd_d;
   logic signed [RW-1:0]    shr_d;
   logic signed [63:0]      ext_d;
   logic signed [63:0]      sat_d;
   logic                    clip_d;
   logic signed [SR-1:0]    out_q;
   logic                    ovalid_q;
   logic                    flag_q;
   logic [15:0]             cnt_q;

   isi_tap_bank #(
      .L    (L),
      .CW   (CW),
      .FRAC (COEF_FRAC),
      .AW   ($clog2(L))
   ) u_tap_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (coef_wr_en),
      .wr_addr_i (coef_wr_addr),
      .wr_data_i (coef_wr_data),
      .commit_i  (coef_commit),
      .active_o  (taps_flat)
   );

   // Delay line after this cycle's sample; products use it with the taps active now
   always_comb begin
      x_d = x_q;
      if (signal_in_valid) begin
         x_d[0] = signal_in;
         for (int k = 1; k < L; k++) begin
            x_d[k] = x_q[k-1];
         end
      end
      for (int k = 0; k < L; k++) begin
         h[k]      = $signed(taps_flat[k*CW +: CW]);
         prod_d[k] = h[k] * x_d[k];
      end
   end

   // Stage 1: delay line, registered products and first valid
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < L; k++) begin
            x_q[k]    <= '0;
            prod_q[k] <= '0;
         end
         v1_q <= 1'b0;
      end else begin
         x_q    <= x_d;
         prod_q <= prod_d;
         v1_q   <= signal_in_valid;
      end
   end

   // Full-precision sum, round half toward +inf, then clip to the output range
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < L; k++) begin
         sum_d = sum_d + ACC'(prod_q[k]);
      end
      rnd_d  = sum_d + ACC'(HALF_I);
      shr_d  = RW'(rnd_d >>> COEF_FRAC);
      ext_d  = 64'(shr_d);
      sat_d  = saturate(ext_d, SR);
      clip_d = (sat_d != ext_d);
   end

   // Stage 2: output register, clip flag and saturating clip counter
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q    <= '0;
         ovalid_q <= 1'b0;
         flag_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         ovalid_q <= v1_q;
         flag_q   <= v1_q && clip_d;
         if (v1_q) begin
            out_q <= SR'(sat_d);
         end
         if (v1_q && clip_d && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign signal_out       = out_q;
   assign signal_out_valid = ovalid_q;
   assign sat_flag         = flag_q;
   assign sat_count        = cnt_q;

endmodule

// File: tb/tb_isi_fir_channel.sv
// tb/tb_isi_fir_channel.sv - randomized and directed check of isi_fir_channel against a schedule model
module tb_isi_fir_channel;
   import isi_channel_pkg::*;

   localparam int L    = 4;
   localparam int SR   = 8;
   localparam int CW   = 8;
   localparam int FRAC = 6;
   localparam int NC   = 4096;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic signed [SR-1:0] signal_in = '0;
   logic                 signal_in_valid = 1'b0;
   logic                 coef_wr_en = 1'b0;
   logic [1:0]           coef_wr_addr = '0;
   logic [CW-1:0]        coef_wr_data = '0;
   logic                 coef_commit = 1'b0;
   logic signed [SR-1:0] signal_out;
   logic                 signal_out_valid;
   logic                 sat_flag;
   logic [15:0]          sat_count;

   isi_fir_channel #(
      .PULSE_RESPONSE_LENGTH (L),
      .SIGNAL_RESOLUTION     (SR),
      .COEF_WIDTH            (CW),
      .COEF_FRAC             (FRAC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .signal_in        (signal_in),
      .signal_in_valid  (signal_in_valid),
      .coef_wr_en       (coef_wr_en),
      .coef_wr_addr     (coef_wr_addr),
      .coef_wr_data     (coef_wr_data),
      .coef_commit      (coef_commit),
      .signal_out       (signal_out),
      .signal_out_valid (signal_out_valid),
      .sat_flag         (sat_flag),
      .sat_count        (sat_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // expected-output schedule indexed by the cycle the output must be visible in
   bit exp_v    [NC+4];
   int exp_y    [NC+4];
   bit exp_f    [NC+4];
   bit rst_mark [NC+4];

   int hist [L];
   int act  [L];
   int shd  [L];
   int m_cnt  = 0;
   int m_last = 0;
   bit armed  = 1'b0;

   int lg_y [$];
   int lg_f [$];
   int lg_c [$];

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int ref_output(input int s[L], input int h[L], output bit clipped);
      int acc;
      int r;
      acc = 0;
      for (int k = 0; k < L; k++) acc += s[k] * h[k];
      r = (acc + (1 << (FRAC - 1))) >>> FRAC;
      clipped = 1'b0;
      if (r > 127) begin r = 127; clipped = 1'b1; end
      if (r < -128) begin r = -128; clipped = 1'b1; end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < L; k++) begin
         hist[k] = 0;
         act[k]  = default_tap(k, FRAC);
         shd[k]  = default_tap(k, FRAC);
      end
   endtask

   // One clock cycle: check what is visible now, then present this cycle's inputs
   task automatic cycle(input bit v, input int d, input bit we, input int wa, input int wd,
                        input bit cm, input bit r);
      bit clipped;
      int y;
      @(negedge clk);
      if (rst_mark[cyc]) begin
         m_last = 0;
         m_cnt  = 0;
         armed  = 1'b1;
      end
      if (armed) begin
         check_eq("out_valid", int'(signal_out_valid), int'(exp_v[cyc]));
         if (exp_v[cyc]) begin
            check_eq("out_value", int'(signal_out), exp_y[cyc]);
            check_eq("sat_flag", int'(sat_flag), int'(exp_f[cyc]));
            if (exp_f[cyc] && m_cnt != 65535) m_cnt++;
            m_last = exp_y[cyc];
            lg_y.push_back(int'(signal_out));
            lg_f.push_back(int'(sat_flag));
            lg_c.push_back(int'(sat_count));
         end else begin
            check_eq("sat_flag_idle", int'(sat_flag), 0);
            check_eq("out_hold", int'(signal_out), m_last);
         end
         check_eq("sat_count", int'(sat_count), m_cnt);
      end
      rst             = r;
      signal_in_valid = v;
      signal_in       = d[SR-1:0];
      coef_wr_en      = we;
      coef_wr_addr    = wa[1:0];
      coef_wr_data    = wd[CW-1:0];
      coef_commit     = cm;
      if (r) begin
         model_reset();
         rst_mark[cyc+1] = 1'b1;
         exp_v[cyc+1]    = 1'b0;
         exp_v[cyc+2]    = 1'b0;
      end else begin
         if (v) begin
            for (int k = L - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = d;
            y = ref_output(hist, act, clipped);
            exp_v[cyc+2] = 1'b1;
            exp_y[cyc+2] = y;
            exp_f[cyc+2] = clipped;
         end
         if (we && wa < L) shd[wa] = wd;
         if (cm) act = shd;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic send(input int d);
      cycle(1, d, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cycle(0, 0, 0, 0, 0, 0, 1);
      lg_y.delete();
      lg_f.delete();
      lg_c.delete();
   endtask

   task automatic check_log(input string tag, input int n, input int e0, input int e1,
                            input int e2, input int e3);
      int ex[4];
      ex = '{e0, e1, e2, e3};
      check_eq({tag, "_count"}, lg_y.size(), n);
      for (int i = 0; i < n; i++) begin
         check_eq(tag, (i < lg_y.size()) ? lg_y[i] : -9999, ex[i]);
      end
   endtask

   initial begin
      coef_t rc;
      for (int i = 0; i < NC + 4; i++) begin
         exp_v[i] = 1'b0; exp_y[i] = 0; exp_f[i] = 1'b0; rst_mark[i] = 1'b0;
      end
      model_reset();
      do_reset();
      do_reset();
      idle(2);

      // legacy channel response
      send(56); send(56); send(0); send(0); idle(3);
      check_log("t1_out", 4, 56, 84, 28, 0);

      // positive clip
      do_reset();
      send(100); send(100); idle(3);
      check_log("t2_pos", 2, 100, 127, 0, 0);
      if (lg_f.size() == 2) begin
         check_eq("t2_flag0", lg_f[0], 0);
         check_eq("t2_flag1", lg_f[1], 1);
         check_eq("t2_cnt", lg_c[1], 1);
      end else check_eq("t2_log_size", lg_f.size(), 2);

      // negative clip
      do_reset();
      send(-128); send(-128); idle(3);
      check_log("t2_neg", 2, -128, -128, 0, 0);
      if (lg_f.size() == 2) begin
         check_eq("t2n_flag0", lg_f[0], 0);
         check_eq("t2n_flag1", lg_f[1], 1);
      end else check_eq("t2n_log_size", lg_f.size(), 2);

      // idle gaps hold the delay line
      do_reset();
      send(40); idle(3); send(40); idle(3);
      check_log("t3_gap", 2, 40, 60, 0, 0);

      // commit with a sample in the same cycle: old taps for that sample
      do_reset();
      cycle(0, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 1, 64, 0, 0);
      cycle(0, 0, 1, 2, 0, 0, 0);
      cycle(1, 16, 1, 3, 0, 1, 0);
      send(24); idle(3);
      check_log("t4_commit", 2, 16, 16, 0, 0);

      // rounding with a single 0.5 tap; commit absorbs a same-cycle write
      do_reset();
      cycle(0, 0, 1, 0, 32, 0, 0);
      cycle(0, 0, 1, 1, 0, 1, 0);
      send(3); send(-3); idle(3);
      check_log("t5_round", 2, 2, -1, 0, 0);

      // reset with two samples in flight
      do_reset();
      send(56);
      cycle(1, 56, 0, 0, 0, 0, 1);
      idle(3);
      check_eq("t6_flushed", lg_y.size(), 0);
      send(56); idle(3);
      check_log("t6_post", 1, 56, 0, 0, 0);
      if (lg_c.size() == 1) check_eq("t6_cnt", lg_c[0], 0);

      // randomized traffic, tap updates, commits and occasional resets
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rc = coef_t'($urandom);
         cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
               $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), int'(rc),
               $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
